receiver: RTL and testbench



---
 rtl/receiver.sv | 78 +++++++
 tb/tb_receiver.sv | 122 ++++++++++++
 2 files changed

// File: rtl/receiver.sv
// Minimal one-clock-per-bit serial receiver: low start bit, DATA_BITS data bits LSB-first,
// no stop bit. Completed word is held on data with rdy high until the next start bit.
module receiver #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x,
  input  logic                 en,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] data
);

  localparam int unsigned CntW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_BITS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rdy_q, rdy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = rdy_q;

    case (state_q)
      IDLE: begin
        if (en && !x) begin
          rdy_d   = 1'b0;
          cnt_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (!en) begin
          // Abort: drop the partial word, outputs keep their last values.
          state_d = IDLE;
        end else begin
          shift_d[cnt_q] = x;
          cnt_d          = cnt_q + CntW'(1);
          if (cnt_q == LastBit) begin
            data_d  = shift_d;
            rdy_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rdy  = rdy_q;
  assign data = data_q;

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: reset, disabled line, framing, back-to-back, abort and
// asynchronous reset mid-frame.
module tb_receiver;

  logic       clk;
  logic       rst;
  logic       x;
  logic       en;
  logic       rdy;
  logic [7:0] data;

  int n_checks = 0;
  int n_fail   = 0;

  receiver #(.DATA_BITS(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .en   (en),
    .rdy  (rdy),
    .data (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, then sample 1 time unit after the next rising edge.
  task automatic step(input logic xv, input logic env);
    x  = xv;
    en = env;
    @(posedge clk);
    #1;
  endtask

  // Start bit then 8 data bits; prev is the word expected on data until completion.
  task automatic send_frame(input string tag, input logic [7:0] w, input logic [7:0] prev);
    step(1'b0, 1'b1);
    check_eq({tag, "_start_rdy"}, {31'b0, rdy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(w[i], 1'b1);
      if (i < 7) begin
        check_eq({tag, "_mid_rdy"}, {31'b0, rdy}, 32'd0);
        check_eq({tag, "_mid_data"}, {24'b0, data}, {24'b0, prev});
      end else begin
        check_eq({tag, "_done_rdy"}, {31'b0, rdy}, 32'd1);
        check_eq({tag, "_done_data"}, {24'b0, data}, {24'b0, w});
      end
    end
  endtask

  initial begin
    logic [7:0] ab;
    rst = 1'b1;
    x   = 1'b1;
    en  = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_eq("reset_data", {24'b0, data}, 32'd0);
    check_eq("reset_rdy", {31'b0, rdy}, 32'd0);
    check_eq("reset_known", {31'b0, $isunknown({rdy, data})}, 32'd0);

    // Disabled: line toggling is ignored.
    for (int i = 0; i < 40; i++) begin
      step(i[0], 1'b0);
      check_eq("dis_data", {24'b0, data}, 32'd0);
      check_eq("dis_rdy", {31'b0, rdy}, 32'd0);
    end

    // Enabled but idle.
    repeat (5) step(1'b1, 1'b1);
    check_eq("idle_data", {24'b0, data}, 32'd0);
    check_eq("idle_rdy", {31'b0, rdy}, 32'd0);

    send_frame("f1", 8'b0001_1100, 8'h00);
    // Back-to-back: start bit in the very next cycle.
    send_frame("f2", 8'hA5, 8'b0001_1100);

    // rdy is a level while the line idles.
    repeat (4) step(1'b1, 1'b1);
    check_eq("level_rdy", {31'b0, rdy}, 32'd1);
    check_eq("level_data", {24'b0, data}, 32'hA5);

    // Abort after 3 data bits.
    ab = 8'h3C;
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(ab[i], 1'b1);
    step(1'b0, 1'b0);
    check_eq("abort_rdy", {31'b0, rdy}, 32'd0);
    check_eq("abort_data", {24'b0, data}, 32'hA5);
    send_frame("f3", 8'h69, 8'hA5);

    // Asynchronous reset mid-frame, away from a clock edge.
    ab = 8'hFF;
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(ab[i], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_data", {24'b0, data}, 32'd0);
    check_eq("arst_rdy", {31'b0, rdy}, 32'd0);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b1);
    check_eq("post_rst_data", {24'b0, data}, 32'd0);
    check_eq("post_rst_rdy", {31'b0, rdy}, 32'd0);
    send_frame("f4", 8'h80, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
